// File: rtl/dram_avalon_bridge_pkg.sv
// Shared types and constants for the MCU DRAM port to Avalon-MM bridge.
package dram_avalon_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_RDATA = 2'd2,
        ST_ACK        = 2'd3
    } state_e;

    // Bit positions inside err_flags
    localparam int ERR_OVERRUN   = 0;
    localparam int ERR_COLLISION = 1;
    localparam int ERR_TIMEOUT   = 2;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1023;

endpackage

// File: rtl/dram_bridge_timeout_counter.sv
// Saturating cycle counter that flags when a read has waited TIMEOUT_CYCLES
// cycles. expired is combinational so the FSM can leave on that same edge.
module dram_bridge_timeout_counter
    import dram_avalon_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic sync_reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_q, count_d;

    // Next count: clear wins, otherwise count up and stick at the limit
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
        expired = (TIMEOUT_CYCLES != 0) && enable && !clear && (count_d == LIMIT);
    end

    // Count register
    always_ff @(posedge clk) begin
        if (sync_reset) count_q <= '0;
        else            count_q <= count_d;
    end

endmodule

// File: rtl/dram_avalon_bridge.sv
// Turns single-cycle MCU DRAM requests into held Avalon-MM commands, collects
// read data, pulses dram_ack, and recovers from a controller that never
// returns read data.
module dram_avalon_bridge
    import dram_avalon_bridge_pkg::*;
#(
    parameter int ADDR_BITS      = 24,
    parameter int DATA_BITS      = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   sync_reset,
    input  logic [ADDR_BITS-1:0]   dram_mem_addr,
    input  logic                   dram_mem_read_en,
    input  logic                   dram_mem_write_en,
    input  logic [DATA_BITS/8-1:0] dram_mem_byte_enable,
    input  logic [DATA_BITS-1:0]   dram_mem_write_data,
    output logic                   dram_ack,
    output logic [DATA_BITS-1:0]   dram_mem_read_data,
    output logic [ADDR_BITS-1:0]   avm_address,
    output logic                   avm_read,
    output logic                   avm_write,
    output logic [DATA_BITS/8-1:0] avm_byteenable,
    output logic [DATA_BITS-1:0]   avm_writedata,
    input  logic                   avm_waitrequest,
    input  logic [DATA_BITS-1:0]   avm_readdata,
    input  logic                   avm_readdatavalid,
    output logic [2:0]             err_flags
);

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_BITS/8-1:0] be_q, be_d;
    logic [DATA_BITS-1:0]   wdata_q, wdata_d;
    logic                   is_write_q, is_write_d;
    logic [DATA_BITS-1:0]   rdata_q, rdata_d;
    logic [2:0]             err_q, err_d;
    logic                   stale_q, stale_d;
    logic                   req;
    logic                   cnt_clear, cnt_enable, cnt_expired;

    dram_bridge_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .sync_reset (sync_reset),
        .clear      (cnt_clear),
        .enable     (cnt_enable),
        .expired    (cnt_expired)
    );

    // Next-state logic: request capture, command handshake, read collection
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        stale_d    = stale_q;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        req        = dram_mem_read_en || dram_mem_write_en;

        // A late beat from a timed-out read is swallowed wherever it lands
        if (stale_q && avm_readdatavalid) stale_d = 1'b0;

        // The MCU must not issue while a request is in flight
        if (req && (state_q != ST_IDLE)) err_d[ERR_OVERRUN] = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d     = dram_mem_addr;
                    be_d       = dram_mem_byte_enable;
                    wdata_d    = dram_mem_write_data;
                    is_write_d = dram_mem_write_en;
                    if (dram_mem_read_en && dram_mem_write_en) err_d[ERR_COLLISION] = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!avm_waitrequest) begin
                    if (is_write_q) begin
                        state_d = ST_ACK;
                    end else begin
                        cnt_clear = 1'b1;
                        state_d   = ST_WAIT_RDATA;
                    end
                end
            end
            ST_WAIT_RDATA: begin
                cnt_enable = 1'b1;
                if (avm_readdatavalid && !stale_q) begin
                    rdata_d = avm_readdata;
                    state_d = ST_ACK;
                end else if (cnt_expired) begin
                    rdata_d            = '0;
                    err_d[ERR_TIMEOUT] = 1'b1;
                    stale_d            = 1'b1;
                    state_d            = ST_ACK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request registers
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
            err_q      <= '0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            stale_q    <= stale_d;
        end
    end

    assign avm_read           = (state_q == ST_ISSUE) && !is_write_q;
    assign avm_write          = (state_q == ST_ISSUE) && is_write_q;
    assign avm_address        = addr_q;
    assign avm_byteenable     = be_q;
    assign avm_writedata      = wdata_q;
    assign dram_ack           = (state_q == ST_ACK);
    assign dram_mem_read_data = rdata_q;
    assign err_flags          = err_q;

endmodule

// File: tb/tb_dram_avalon_bridge.sv
// Directed bench for dram_avalon_bridge with a transaction-level reference
// model compared every cycle, plus literal expectations per scenario.
module tb_dram_avalon_bridge;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          sync_reset;
    logic [AW-1:0] dram_mem_addr;
    logic          dram_mem_read_en, dram_mem_write_en;
    logic [3:0]    dram_mem_byte_enable;
    logic [DW-1:0] dram_mem_write_data;
    logic          dram_ack;
    logic [DW-1:0] dram_mem_read_data;
    logic [AW-1:0] avm_address;
    logic          avm_read, avm_write;
    logic [3:0]    avm_byteenable;
    logic [DW-1:0] avm_writedata;
    logic          avm_waitrequest;
    logic [DW-1:0] avm_readdata;
    logic          avm_readdatavalid;
    logic [2:0]    err_flags;

    int checks = 0;
    int failures = 0;

    dram_avalon_bridge #(.ADDR_BITS(AW), .DATA_BITS(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .sync_reset(sync_reset),
        .dram_mem_addr(dram_mem_addr), .dram_mem_read_en(dram_mem_read_en),
        .dram_mem_write_en(dram_mem_write_en), .dram_mem_byte_enable(dram_mem_byte_enable),
        .dram_mem_write_data(dram_mem_write_data), .dram_ack(dram_ack),
        .dram_mem_read_data(dram_mem_read_data), .avm_address(avm_address),
        .avm_read(avm_read), .avm_write(avm_write), .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction view) ----------------
    // m_cmd: a command is being presented; m_rd_wait: read accepted, data owed;
    // m_ack: completion is presented this cycle; m_waited: cycles owed so far.
    bit            m_cmd, m_rd_wait, m_ack, m_wr, m_stale;
    int            m_waited;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_be;
    logic [DW-1:0] m_wd, m_rdata;
    logic [2:0]    m_err;

    always @(posedge clk) begin
        if (sync_reset) begin
            m_cmd = 0; m_rd_wait = 0; m_ack = 0; m_wr = 0; m_stale = 0; m_waited = 0;
            m_addr = '0; m_be = '0; m_wd = '0; m_rdata = '0; m_err = '0;
        end else begin
            bit req, busy, stale_seen;
            req = dram_mem_read_en || dram_mem_write_en;
            busy = m_cmd || m_rd_wait || m_ack;
            stale_seen = m_stale && avm_readdatavalid;
            if (stale_seen) m_stale = 0;
            if (req && busy) m_err[0] = 1'b1;
            if (m_ack) begin
                m_ack = 0;
            end else if (m_cmd) begin
                if (!avm_waitrequest) begin
                    m_cmd = 0;
                    if (m_wr) m_ack = 1;
                    else begin m_rd_wait = 1; m_waited = 0; end
                end
            end else if (m_rd_wait) begin
                m_waited++;
                if (avm_readdatavalid && !stale_seen) begin
                    m_rdata = avm_readdata; m_rd_wait = 0; m_ack = 1;
                end else if (TO != 0 && m_waited >= TO) begin
                    m_rdata = '0; m_err[2] = 1'b1; m_stale = 1; m_rd_wait = 0; m_ack = 1;
                end
            end else if (req) begin
                m_addr = dram_mem_addr; m_be = dram_mem_byte_enable;
                m_wd = dram_mem_write_data; m_wr = dram_mem_write_en;
                if (dram_mem_read_en && dram_mem_write_en) m_err[1] = 1'b1;
                m_cmd = 1;
            end
        end
    end

    // Single compare process on the falling edge
    always @(negedge clk) begin
        chk("m_ack", {63'b0, dram_ack}, {63'b0, m_ack});
        chk("m_read", {63'b0, avm_read}, {63'b0, m_cmd && !m_wr});
        chk("m_write", {63'b0, avm_write}, {63'b0, m_cmd && m_wr});
        chk("m_rdata", {32'b0, dram_mem_read_data}, {32'b0, m_rdata});
        chk("m_err", {61'b0, err_flags}, {61'b0, m_err});
        if (m_cmd) begin
            chk("m_addr", {40'b0, avm_address}, {40'b0, m_addr});
            chk("m_be", {60'b0, avm_byteenable}, {60'b0, m_be});
            if (m_wr) chk("m_wdata", {32'b0, avm_writedata}, {32'b0, m_wd});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int n_rd, n_wr, k, hit;
        sync_reset = 1; dram_mem_addr = '0; dram_mem_read_en = 0; dram_mem_write_en = 0;
        dram_mem_byte_enable = '0; dram_mem_write_data = '0;
        avm_waitrequest = 0; avm_readdata = '0; avm_readdatavalid = 0;
        tick(); tick();
        chk("reset_ack", {63'b0, dram_ack}, 64'd0);
        chk("reset_cmd", {62'b0, avm_read, avm_write}, 64'd0);
        chk("reset_err", {61'b0, err_flags}, 64'd0);
        chk("reset_rdata", {32'b0, dram_mem_read_data}, 64'd0);
        sync_reset = 0;
        tick();

        // Write, zero waitstates
        dram_mem_write_en = 1; dram_mem_addr = 24'h000123;
        dram_mem_write_data = 32'hCAFEF00D; dram_mem_byte_enable = 4'hF;
        tick(); dram_mem_write_en = 0;
        chk("wr_c1_write", {63'b0, avm_write}, 64'd1);
        chk("wr_c1_addr", {40'b0, avm_address}, 64'h123);
        chk("wr_c1_data", {32'b0, avm_writedata}, 64'hCAFEF00D);
        chk("wr_c1_be", {60'b0, avm_byteenable}, 64'hF);
        tick();
        chk("wr_c2_ack", {63'b0, dram_ack}, 64'd1);
        tick();
        chk("wr_c3_ack", {63'b0, dram_ack}, 64'd0);
        chk("wr_err", {61'b0, err_flags}, 64'd0);

        // Read with 3 stall cycles, data 2 cycles after acceptance
        dram_mem_read_en = 1; dram_mem_addr = 24'h000040; avm_waitrequest = 1;
        tick(); dram_mem_read_en = 0;
        n_rd = 0;
        for (int i = 0; i < 3; i++) begin
            if (avm_read) n_rd++;
            tick();
        end
        avm_waitrequest = 0;
        if (avm_read) n_rd++;
        tick();
        tick();
        avm_readdatavalid = 1; avm_readdata = 32'h12345678;
        tick(); avm_readdatavalid = 0; avm_readdata = '0;
        chk("rd_held_cycles", 64'(n_rd), 64'd4);
        chk("rd_ack", {63'b0, dram_ack}, 64'd1);
        chk("rd_data", {32'b0, dram_mem_read_data}, 64'h12345678);
        tick();

        // Timeout then stale drop
        dram_mem_read_en = 1; dram_mem_addr = 24'h000080;
        tick(); dram_mem_read_en = 0;
        tick();
        hit = 0;
        for (k = 1; k <= 20; k++) begin
            if (dram_ack) begin hit = k; break; end
            tick();
        end
        chk("to_ack_offset", 64'(hit), 64'd9);
        chk("to_data", {32'b0, dram_mem_read_data}, 64'd0);
        chk("to_err2", {63'b0, err_flags[2]}, 64'd1);
        tick();
        dram_mem_read_en = 1; dram_mem_addr = 24'h000084;
        tick(); dram_mem_read_en = 0;
        tick();
        avm_readdatavalid = 1; avm_readdata = 32'hAAAAAAAA;
        tick(); avm_readdatavalid = 0;
        tick();
        avm_readdatavalid = 1; avm_readdata = 32'h55555555;
        tick(); avm_readdatavalid = 0; avm_readdata = '0;
        chk("stale_ack", {63'b0, dram_ack}, 64'd1);
        chk("stale_data", {32'b0, dram_mem_read_data}, 64'h55555555);
        tick();

        // Overrun: second write while in ISSUE
        dram_mem_write_en = 1; dram_mem_addr = 24'h000200;
        dram_mem_write_data = 32'h11112222; dram_mem_byte_enable = 4'h3; avm_waitrequest = 1;
        tick(); dram_mem_write_en = 0;
        n_wr = 0;
        dram_mem_write_en = 1; dram_mem_addr = 24'h000300; dram_mem_write_data = 32'h99999999;
        tick(); dram_mem_write_en = 0;
        tick();
        avm_waitrequest = 0;
        for (int i = 0; i < 8; i++) begin
            if (avm_write && !avm_waitrequest) n_wr++;
            tick();
        end
        chk("ovr_one_write", 64'(n_wr), 64'd1);
        chk("ovr_err0", {63'b0, err_flags[0]}, 64'd1);

        // Collision: read and write together behave as a write
        dram_mem_read_en = 1; dram_mem_write_en = 1; dram_mem_addr = 24'h000310;
        dram_mem_write_data = 32'h0BADBEEF; dram_mem_byte_enable = 4'hC;
        tick(); dram_mem_read_en = 0; dram_mem_write_en = 0;
        n_rd = 0; n_wr = 0;
        for (int i = 0; i < 6; i++) begin
            if (avm_read) n_rd++;
            if (avm_write) n_wr++;
            tick();
        end
        chk("col_no_read", 64'(n_rd), 64'd0);
        chk("col_one_write", 64'(n_wr), 64'd1);
        chk("col_err1", {63'b0, err_flags[1]}, 64'd1);

        // Reset during WAIT_RDATA
        dram_mem_read_en = 1; dram_mem_addr = 24'h000400;
        tick(); dram_mem_read_en = 0;
        tick(); tick();
        sync_reset = 1;
        tick(); sync_reset = 0;
        chk("rst_ack", {63'b0, dram_ack}, 64'd0);
        chk("rst_cmd", {62'b0, avm_read, avm_write}, 64'd0);
        chk("rst_addr", {40'b0, avm_address}, 64'd0);
        chk("rst_err", {61'b0, err_flags}, 64'd0);
        avm_readdatavalid = 1; avm_readdata = 32'hDEADDEAD;
        tick(); avm_readdatavalid = 0; avm_readdata = '0;
        chk("late_rdv_ack", {63'b0, dram_ack}, 64'd0);
        chk("late_rdv_data", {32'b0, dram_mem_read_data}, 64'd0);
        dram_mem_write_en = 1; dram_mem_addr = 24'h000010;
        dram_mem_write_data = 32'h01020304; dram_mem_byte_enable = 4'hF;
        tick(); dram_mem_write_en = 0;
        hit = 0;
        for (k = 1; k <= 6; k++) begin
            if (dram_ack) begin hit = k; break; end
            tick();
        end
        chk("post_rst_write_ack", 64'(hit), 64'd2);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
